// File: rtl/phy_ctrl_pkg.sv
// Shared definitions for the PHY link controller.
//   link_state_e  : TRAIN / WAIT_LOCK / LINK_UP
//   DATA_W_DEF    : default requester/PHY word width
//   RC_W          : width of the retrain event counter
//   sat_inc_rc()  : saturating increment for the retrain counter
package phy_ctrl_pkg;

    typedef enum logic [1:0] {
        TRAIN     = 2'd0,
        WAIT_LOCK = 2'd1,
        LINK_UP   = 2'd2
    } link_state_e;

    localparam int DATA_W_DEF = 32;
    localparam int RC_W       = 8;

    function automatic logic [RC_W-1:0] sat_inc_rc(input logic [RC_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/phy_rr_arb2.sv
// Two-requester arbiter producing a one-hot grant.
// Policy is selected by PHY_LINK_CTRL_ROUND_ROBIN_EN:
//   defined   : round robin, the requester other than last_grant_i wins a tie
//   undefined : fixed priority, requester 0 wins whenever it is valid
// Ports:
//   valid_i[1:0]  requester valids
//   last_grant_i  index of the requester most recently accepted
//   en_i          arbitration allowed this cycle (no grant when low)
//   gnt_o[1:0]    one-hot grant, all zero when nothing is granted
module phy_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

`ifdef PHY_LINK_CTRL_ROUND_ROBIN_EN
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (valid_i == 2'b11) begin
                gnt_o = last_grant_i ? 2'b01 : 2'b10;
            end else begin
                gnt_o = valid_i;
            end
        end
    end
`else
    // Fixed priority has no use for the previous grant.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (valid_i[0]) begin
                gnt_o = 2'b01;
            end else if (valid_i[1]) begin
                gnt_o = 2'b10;
            end
        end
    end
`endif

endmodule

// File: rtl/phy_link_ctrl.sv
// Link controller and two-requester arbiter in front of the PHY transmit path.
// Holds the PHY in training (phy_valid=0, serializer sends idle COM) until the
// receiver reports lock, then shares the PHY input between two requesters.
// Loss of lock or a retrain pulse drops the link back to TRAIN; every TRAIN
// entry except the one out of reset bumps a saturating retrain counter.
// Optional feature macro: PHY_LINK_CTRL_ROUND_ROBIN_EN (round-robin arbitration;
// fixed priority to requester 0 when undefined).
// Handshake: a word moves when reqN_valid && reqN_ready in the same cycle;
// ready is combinational from valid, state, rx_active and retrain, and a
// requester must hold valid and data stable until accepted.
// Ports:
//   clk_f, reset               clock, synchronous active-high reset
//   req0_*/req1_*              requester data/valid in, ready out
//   rx_active                  receiver lock indication
//   retrain                    single-cycle request to force training
//   phy_data, phy_valid        registered word to the PHY
//   link_up                    registered, high only in LINK_UP
//   grant                      index of the requester most recently accepted
//   retrain_count              saturating count of TRAIN re-entries
module phy_link_ctrl
    import phy_ctrl_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int TRAIN_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic              clk_f,
    input  logic              reset,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              rx_active,
    input  logic              retrain,
    output logic [DATA_W-1:0] phy_data,
    output logic              phy_valid,
    output logic              link_up,
    output logic              grant,
    output logic [RC_W-1:0]   retrain_count
);

    localparam int CNT_MAX = (TRAIN_CYCLES > LOCK_TIMEOUT) ? TRAIN_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    link_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] phy_data_q, phy_data_d;
    logic              phy_valid_q, phy_valid_d;
    logic              link_up_q;
    logic              grant_q, grant_d;
    logic [RC_W-1:0]   rc_q, rc_d;

    logic              arb_en;
    logic [1:0]        gnt;
    logic              xfer;
    logic              enter_train;

    // Losing lock or a retrain pulse in the same cycle blocks the transfer.
    assign arb_en = (state_q == LINK_UP) && rx_active && !retrain;

    phy_rr_arb2 u_arb (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (grant_q),
        .en_i         (arb_en),
        .gnt_o        (gnt)
    );

    assign xfer = |gnt;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enter_train = 1'b0;
        if (retrain) begin
            state_d     = TRAIN;
            cnt_d       = '0;
            enter_train = 1'b1;
        end else begin
            case (state_q)
                TRAIN: begin
                    if (cnt_q == CNT_W'(TRAIN_CYCLES - 1)) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (rx_active) begin
                        state_d = LINK_UP;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_d     = TRAIN;
                        cnt_d       = '0;
                        enter_train = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                LINK_UP: begin
                    if (!rx_active) begin
                        state_d     = TRAIN;
                        cnt_d       = '0;
                        enter_train = 1'b1;
                    end
                end
                default: begin
                    state_d = TRAIN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        phy_valid_d = xfer;
        phy_data_d  = phy_data_q;
        grant_d     = grant_q;
        if (xfer) begin
            phy_data_d = gnt[1] ? req1_data : req0_data;
            grant_d    = gnt[1];
        end
        rc_d = enter_train ? sat_inc_rc(rc_q) : rc_q;
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            state_q     <= TRAIN;
            cnt_q       <= '0;
            phy_data_q  <= '0;
            phy_valid_q <= 1'b0;
            link_up_q   <= 1'b0;
            grant_q     <= 1'b0;
            rc_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phy_data_q  <= phy_data_d;
            phy_valid_q <= phy_valid_d;
            link_up_q   <= (state_d == LINK_UP);
            grant_q     <= grant_d;
            rc_q        <= rc_d;
        end
    end

    assign req0_ready    = gnt[0];
    assign req1_ready    = gnt[1];
    assign phy_data      = phy_data_q;
    assign phy_valid     = phy_valid_q;
    assign link_up       = link_up_q;
    assign grant         = grant_q;
    assign retrain_count = rc_q;

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Self-checking bench for phy_link_ctrl: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural link/arbiter model.
module tb_phy_link_ctrl;

    localparam int DW = 32;
    localparam int TC = 16;
    localparam int LT = 64;

    // ---------------- clock / reset ----------------
    logic          clk_f = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic          rx_active, retrain;
    logic [DW-1:0] phy_data;
    logic          phy_valid, link_up, grant;
    logic [7:0]    retrain_count;

    always #5 clk_f = ~clk_f;

    phy_link_ctrl #(
        .DATA_W       (DW),
        .TRAIN_CYCLES (TC),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk_f         (clk_f),
        .reset         (reset),
        .req0_data     (req0_data),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req1_data     (req1_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .rx_active     (rx_active),
        .retrain       (retrain),
        .phy_data      (phy_data),
        .phy_valid     (phy_valid),
        .link_up       (link_up),
        .grant         (grant),
        .retrain_count (retrain_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 training, 1 waiting for lock, 2 link up; t counts cycles in phase.
    int            m_phase = 0;
    int            m_t = 0;
    int            m_rc = 0;
    logic [DW-1:0] m_data = '0;
    bit            m_valid = 1'b0;
    bit            m_grant = 1'b0;
    bit            m_acc0 = 1'b0;
    bit            m_acc1 = 1'b0;
    bit            m_started = 1'b0;
    logic [1:0]    m_r;
    logic [DW-1:0] exp_q[$];

    // Which requester the link accepts this cycle, from the arbitration rules.
    function automatic logic [1:0] m_ready();
        if (m_phase != 2 || !rx_active || retrain) return 2'b00;
        if (req0_valid && req1_valid) begin
`ifdef PHY_LINK_CTRL_ROUND_ROBIN_EN
            return m_grant ? 2'b01 : 2'b10;
`else
            return 2'b01;
`endif
        end
        return {req1_valid, req0_valid};
    endfunction

    always @(posedge clk_f) begin
        if (reset) begin
            m_phase = 0; m_t = 0; m_rc = 0;
            m_data = '0; m_valid = 0; m_grant = 0;
            m_acc0 = 0; m_acc1 = 0; m_started = 1;
            exp_q.delete();
        end else begin
            m_r = m_ready();
            m_acc0 = m_r[0];
            m_acc1 = m_r[1];
            m_valid = (m_r != 2'b00);
            if (m_valid) begin
                m_data  = m_r[1] ? req1_data : req0_data;
                m_grant = m_r[1];
                exp_q.push_back(m_data);
            end
            if (retrain || (m_phase == 2 && !rx_active) ||
                (m_phase == 1 && !rx_active && m_t + 1 == LT)) begin
                m_phase = 0; m_t = 0;
                if (m_rc < 255) m_rc++;
            end else if (m_phase == 0) begin
                m_t++;
                if (m_t == TC) begin m_phase = 1; m_t = 0; end
            end else if (m_phase == 1) begin
                if (rx_active) begin m_phase = 2; m_t = 0; end
                else m_t++;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    int            rdy1_cnt = 0;
    int            pv_cnt = 0;
    logic [DW-1:0] obs_q[$];
    logic [DW-1:0] got;

    always @(negedge clk_f) begin
        if (m_started) begin
            check("link_up", 32'(link_up), 32'(m_phase == 2));
            check("phy_valid", 32'(phy_valid), 32'(m_valid));
            check("phy_data", phy_data, m_data);
            check("grant", 32'(grant), 32'(m_grant));
            check("retrain_count", 32'(retrain_count), 32'(m_rc));
            check("readies", 32'({req1_ready, req0_ready}), 32'(m_ready()));
            if (phy_valid) begin
                obs_q.push_back(phy_data);
                pv_cnt++;
                if (exp_q.size() == 0) begin
                    check("word_order_unexpected", phy_data, 32'hFFFF_FFFF);
                end else begin
                    got = exp_q.pop_front();
                    check("word_order", phy_data, got);
                end
            end
            if (req1_ready) rdy1_cnt++;
        end
    end

    // ---------------- driver ----------------
    int idx0 = 0, idx1 = 0;
    int p0 = 0, p1 = 0;

    task automatic set_data();
        req0_data = 32'hA000_0000 + 32'(idx0);
        req1_data = 32'hB000_0000 + 32'(idx1);
    endtask

    // One clock: inputs change 1 time unit after the edge; a requester holds
    // its word until accepted, then raises the next one with probability pN%.
    task automatic step();
        @(posedge clk_f);
        #1;
        retrain = 1'b0;
        if (m_acc0) begin
            idx0++;
            req0_valid = ($urandom_range(0, 99) < p0);
        end else if (!req0_valid) begin
            req0_valid = ($urandom_range(0, 99) < p0);
        end
        if (m_acc1) begin
            idx1++;
            req1_valid = ($urandom_range(0, 99) < p1);
        end else if (!req1_valid) begin
            req1_valid = ($urandom_range(0, 99) < p1);
        end
        set_data();
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        p0 = 0; p1 = 0;
        while ((req0_valid || req1_valid) && g < 60) begin
            step();
            g++;
        end
        check(name, 32'(req0_valid || req1_valid), 32'd0);
    endtask

    logic [DW-1:0] exp_seq[4];

    initial begin
        rx_active = 1'b1; retrain = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        set_data();

        // Reset, lock present from the start.
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (TC) step();
        check("lit_link_up_after_16", 32'(link_up), 32'd0);
        check("lit_phy_valid_train", 32'(phy_valid), 32'd0);
        step();
        check("lit_link_up_after_17", 32'(link_up), 32'd1);
        check("lit_rc_zero", 32'(retrain_count), 32'd0);

        // Only requester 1 valid for 5 cycles.
        rdy1_cnt = 0; pv_cnt = 0;
        p1 = 100; req1_valid = 1'b1; set_data();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) p1 = 0;
            step();
        end
        repeat (3) step();
        check("lit_req1_ready_cycles", 32'(rdy1_cnt), 32'd5);
        check("lit_req1_words", 32'(pv_cnt), 32'd5);
        check("lit_grant_req1", 32'(grant), 32'd1);

        // Both valid continuously.
        idx0 = 0; idx1 = 0; obs_q.delete();
        p0 = 100; p1 = 100; req0_valid = 1'b1; req1_valid = 1'b1; set_data();
        repeat (8) step();
        drain("drain_both");
        repeat (2) step();
`ifdef PHY_LINK_CTRL_ROUND_ROBIN_EN
        exp_seq[0] = 32'hA000_0000; exp_seq[1] = 32'hB000_0000;
        exp_seq[2] = 32'hA000_0001; exp_seq[3] = 32'hB000_0001;
`else
        exp_seq[0] = 32'hA000_0000; exp_seq[1] = 32'hA000_0001;
        exp_seq[2] = 32'hA000_0002; exp_seq[3] = 32'hA000_0003;
`endif
        check("lit_seq_len", 32'(obs_q.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k < obs_q.size()) check("lit_seq_word", obs_q[k], exp_seq[k]);
        end

        // Drop lock for one cycle while both requesters are valid.
        p0 = 100; p1 = 100; req0_valid = 1'b1; req1_valid = 1'b1; set_data();
        repeat (2) step();
        rx_active = 1'b0;
        step();
        rx_active = 1'b1;
        check("lit_link_down", 32'(link_up), 32'd0);
        check("lit_rc_after_drop", 32'(retrain_count), 32'd1);
        p0 = 0; p1 = 0;
        drain("drain_after_drop");
        repeat (3) step();
        check("lit_relinked", 32'(link_up), 32'd1);

        // retrain and lock loss in the same LINK_UP cycle: one entry only.
        retrain = 1'b1; rx_active = 1'b0;
        step();
        rx_active = 1'b1;
        check("lit_rc_single_inc", 32'(retrain_count), 32'd2);
        repeat (20) step();

        // Randomized traffic, lock glitches, retrain pulses and resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                p0 = $urandom_range(0, 100);
                p1 = $urandom_range(0, 100);
            end
            rx_active = ($urandom_range(0, 99) >= 4);
            if ($urandom_range(0, 99) < 2) retrain = 1'b1;
            if ($urandom_range(0, 999) == 0) reset = 1'b1;
            step();
            reset = 1'b0;
        end
        p0 = 0; p1 = 0;
        rx_active = 1'b1;
        drain("drain_random");

        // Lock never arrives: TRAIN/WAIT_LOCK loop and counter saturation.
        req0_valid = 1'b0; req1_valid = 1'b0;
        rx_active = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (TC + LT - 1) step();
        check("lit_rc_before_timeout", 32'(retrain_count), 32'd0);
        step();
        check("lit_rc_first_timeout", 32'(retrain_count), 32'd1);
        check("lit_link_up_timeout", 32'(link_up), 32'd0);
        repeat (260 * (TC + LT)) step();
        check("lit_rc_saturated", 32'(retrain_count), 32'd255);

        step();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
